// File: rtl/alu_pkg.sv
// Shared ALU32 shifter definitions.
// Width defaults and the iterative shifter state encoding.
package alu_pkg;

  localparam int unsigned ALU_N = 32;
  localparam int unsigned ALU_M = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } shift_state_t;

endpackage

// File: rtl/sll_iterative.sv
// Multi-cycle logical shift-left unit.
// One bit position per clock; DONE strobes once with Y held after.
module sll_iterative
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_N,
  parameter int unsigned M = ALU_M
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [M-1:0] SHIFT_AMT,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] Y
);

  shift_state_t state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          data_d  = A;
          cnt_d   = SHIFT_AMT;
          state_d = (SHIFT_AMT == '0) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        data_d = {data_q[N-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == M'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Y    = data_q;

endmodule

// File: tb/tb_sll_iterative.sv
// Scoreboard bench for sll_iterative.
// Driver queues expected result and DONE cycle; monitor checks.
module tb_sll_iterative;

  typedef struct {
    logic [31:0] y;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  sll_iterative #(.N(32), .M(5)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .A        (a),
    .SHIFT_AMT(amt),
    .BUSY     (busy),
    .DONE     (done),
    .Y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h",
               name, cyc, act, exp);
    end
  endtask

  // Monitor: every DONE must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y_at_done", y, e.y);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic op(input logic [31:0] av, input logic [4:0] kv);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    amt   = kv;
    e.y   = av << kv;
    e.due = cyc + 1 + int'(kv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    amt   = 5'($urandom);
    for (int i = 0; i < int'(kv); i++) begin
      chk("busy_shift", {31'd0, busy}, 32'd1);
      chk("no_early_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("busy_finish", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    amt   = '0;
    checks = 0;
    errors = 0;
    repeat (3) @(negedge clk);
    chk("rst_y", y, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    op(32'h0000_0001, 5'd31);
    chk("y_k31_hold", y, 32'h8000_0000);
    op(32'hDEAD_BEEF, 5'd0);
    op(32'hFFFF_FFFF, 5'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("y_hold", y, 32'hFFFF_FFF0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // START held high; inputs disturbed mid-operation.
    @(negedge clk);
    c     = cyc;
    start = 1'b1;
    a     = 32'h1234_5678;
    amt   = 5'd8;
    e.y   = 32'h3456_7800;
    e.due = c + 9;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    a   = 32'hFFFF_FFFF;
    amt = 5'd3;
    repeat (7) @(negedge clk);
    chk("held_y_finish", y, 32'h3456_7800);
    a     = 32'h1234_5678;
    amt   = 5'd8;
    e.due = c + 19;
    sb.push_back(e);
    @(negedge clk);
    chk("held_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("held_restart_busy", {31'd0, busy}, 32'd1);
    repeat (8) @(negedge clk);
    @(negedge clk);

    // Abort a k=20 operation with reset.
    @(negedge clk);
    start = 1'b1;
    a     = 32'hCAFE_F00D;
    amt   = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_y", y, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 1000; i++) begin
      op($urandom, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
